avalon_mem_arbiter: RTL and testbench

- Shares one Avalon-MM memory port, e.g. a dual_port_bram port, between two Avalon-MM masters: m0, typically the Clarvi data port, and m1, typically a debug loader or DMA engine.
- Round-robin arbitration of commands.
- Holds the grant while the memory stalls.
- Routes pipelined read responses back to the requester in issue order through an ID FIFO.

---
 rtl/avalon_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_avalon_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_arbiter.sv
// rtl/avalon_mem_arbiter.sv - two-master Avalon-MM arbiter sharing one memory port
//
// Purpose:
//   Round-robin arbitration of commands from two Avalon-MM masters (m0, m1)
//   onto a single memory port. The grant is held while the memory stalls.
//   Pipelined read responses are routed back to their issuer, in issue
//   order, through a 1-bit ID FIFO.
//
// Ports:
//   clock, reset           system clock, asynchronous active-high reset
//   avs_m0_* / avs_m1_*    slave-side ports facing the two masters
//   avm_*                  master-side port facing the shared memory
//   protocol_error         sticky; a read response arrived with none pending
module avalon_mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] avs_m0_address,
  input  logic [3:0]            avs_m0_byteenable,
  input  logic                  avs_m0_read,
  input  logic                  avs_m0_write,
  input  logic [31:0]           avs_m0_writedata,
  output logic [31:0]           avs_m0_readdata,
  output logic                  avs_m0_waitrequest,
  output logic                  avs_m0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0] avs_m1_address,
  input  logic [3:0]            avs_m1_byteenable,
  input  logic                  avs_m1_read,
  input  logic                  avs_m1_write,
  input  logic [31:0]           avs_m1_writedata,
  output logic [31:0]           avs_m1_readdata,
  output logic                  avs_m1_waitrequest,
  output logic                  avs_m1_readdatavalid,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic [3:0]            avm_byteenable,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_waitrequest,
  input  logic                  avm_readdatavalid,
  output logic                  protocol_error
);

  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t state, state_next;
  logic   prio;
  logic   locked_id;

  logic   req0, req1;
  logic   grant_valid, grant_id;
  logic   sel_read, sel_write;
  logic   gnt_read, gnt_write;
  logic   read_stall, presented, accept;

  logic [MAX_PENDING-1:0] fifo_mem;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full, fifo_empty, fifo_head;
  logic                   push, pop;

  assign req0 = avs_m0_read | avs_m0_write;
  assign req1 = avs_m1_read | avs_m1_write;

  // Grant selection and next state. While reset is high no grant is issued,
  // so the memory sees no command and both masters see waitrequest.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    state_next  = state;
    case (state)
      IDLE: begin
        if (req0 && req1) grant_id = prio;
        else if (req1)    grant_id = 1'b1;
        else              grant_id = 1'b0;
        grant_valid = req0 | req1;
        if (presented && avm_waitrequest) state_next = LOCKED;
      end
      LOCKED: begin
        grant_id    = locked_id;
        grant_valid = locked_id ? req1 : req0;
        // A withdrawn command or an acceptance both release the lock.
        if (!grant_valid || accept) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) grant_valid = 1'b0;
  end

  // Read wins over write when a master asserts both.
  assign sel_read  = grant_id ? avs_m1_read  : avs_m0_read;
  assign sel_write = grant_id ? avs_m1_write : avs_m0_write;
  assign gnt_read  = grant_valid & sel_read;
  assign gnt_write = grant_valid & ~sel_read & sel_write;

  assign fifo_full  = (fifo_count == CNT_W'(MAX_PENDING));
  assign fifo_empty = (fifo_count == '0);
  assign read_stall = gnt_read & fifo_full;

  // A stalled read is not presented at all, so the memory never accepts a
  // read whose response could not be tracked.
  assign avm_read   = gnt_read & ~read_stall;
  assign avm_write  = gnt_write;
  assign presented  = avm_read | avm_write;
  assign accept     = presented & ~avm_waitrequest;

  assign avm_address    = grant_id ? avs_m1_address    : avs_m0_address;
  assign avm_byteenable = grant_id ? avs_m1_byteenable : avs_m0_byteenable;
  assign avm_writedata  = grant_id ? avs_m1_writedata  : avs_m0_writedata;

  assign avs_m0_waitrequest = ~(grant_valid & ~grant_id) | avm_waitrequest | read_stall;
  assign avs_m1_waitrequest = ~(grant_valid &  grant_id) | avm_waitrequest | read_stall;

  // Responses with nothing outstanding are dropped here; fifo_count is held
  // at zero by reset, so no response leaks out while reset is high.
  assign push      = accept & gnt_read;
  assign pop       = avm_readdatavalid & ~fifo_empty;
  assign fifo_head = fifo_mem[rd_ptr];

  assign avs_m0_readdatavalid = pop & ~fifo_head;
  assign avs_m1_readdatavalid = pop &  fifo_head;
  assign avs_m0_readdata      = avm_readdata;
  assign avs_m1_readdata      = avm_readdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      prio           <= 1'b0;
      locked_id      <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      protocol_error <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == LOCKED) locked_id <= grant_id;
      if (accept) prio <= ~grant_id;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (avm_readdatavalid && fifo_empty) protocol_error <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= grant_id;
  end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// tb/tb_avalon_mem_arbiter.sv - directed self-checking bench for avalon_mem_arbiter
module tb_avalon_mem_arbiter;

  logic        clock;
  logic        reset;
  logic [15:0] avs_m0_address, avs_m1_address, avm_address;
  logic [3:0]  avs_m0_byteenable, avs_m1_byteenable, avm_byteenable;
  logic        avs_m0_read, avs_m0_write, avs_m1_read, avs_m1_write;
  logic [31:0] avs_m0_writedata, avs_m1_writedata, avm_writedata;
  logic [31:0] avs_m0_readdata, avs_m1_readdata, avm_readdata;
  logic        avs_m0_waitrequest, avs_m1_waitrequest;
  logic        avs_m0_readdatavalid, avs_m1_readdatavalid;
  logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic        protocol_error;

  int n_cmp = 0;
  int n_err = 0;

  logic        mem_auto;
  logic        rd_acc;
  logic [15:0] rd_addr;
  logic [31:0] mem_model [0:255];

  avalon_mem_arbiter #(.ADDR_WIDTH(16), .MAX_PENDING(4)) dut (
    .clock(clock), .reset(reset),
    .avs_m0_address(avs_m0_address), .avs_m0_byteenable(avs_m0_byteenable),
    .avs_m0_read(avs_m0_read), .avs_m0_write(avs_m0_write),
    .avs_m0_writedata(avs_m0_writedata), .avs_m0_readdata(avs_m0_readdata),
    .avs_m0_waitrequest(avs_m0_waitrequest), .avs_m0_readdatavalid(avs_m0_readdatavalid),
    .avs_m1_address(avs_m1_address), .avs_m1_byteenable(avs_m1_byteenable),
    .avs_m1_read(avs_m1_read), .avs_m1_write(avs_m1_write),
    .avs_m1_writedata(avs_m1_writedata), .avs_m1_readdata(avs_m1_readdata),
    .avs_m1_waitrequest(avs_m1_waitrequest), .avs_m1_readdatavalid(avs_m1_readdatavalid),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid), .protocol_error(protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory with 1-cycle read latency, active only while mem_auto is set.
  always begin
    @(negedge clock);
    rd_acc  = mem_auto & avm_read & ~avm_waitrequest;
    rd_addr = avm_address;
    if (mem_auto && avm_write && !avm_waitrequest) mem_model[avm_address[7:0]] = avm_writedata;
    @(posedge clock);
    #1;
    if (mem_auto) begin
      avm_readdatavalid = rd_acc;
      avm_readdata      = rd_acc ? mem_model[rd_addr[7:0]] : 32'h0;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_masters();
    avs_m0_read = 0; avs_m0_write = 0; avs_m1_read = 0; avs_m1_write = 0;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    avs_m0_read = 1'b1; avs_m0_address = 16'h0001;
    #2;
    n_cmp++; if (avm_read !== 1'b0) begin n_err++; $display("FAIL rst_avm_read got %b exp 0", avm_read); end
    n_cmp++; if (avs_m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_m0_wait got %b exp 1", avs_m0_waitrequest); end
    n_cmp++; if (avs_m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_m1_wait got %b exp 1", avs_m1_waitrequest); end
    n_cmp++; if (protocol_error !== 1'b0) begin n_err++; $display("FAIL rst_perr got %b exp 0", protocol_error); end
    cyc();
    reset = 1'b0;
    clear_masters();
  endtask

  task automatic test_single();
    cyc();
    avs_m0_write = 1; avs_m0_address = 16'h0010; avs_m0_writedata = 32'hDEADBEEF; avs_m0_byteenable = 4'hF;
    #2;
    n_cmp++; if (avm_write !== 1'b1) begin n_err++; $display("FAIL single_avm_write got %b exp 1", avm_write); end
    n_cmp++; if (avm_address !== 16'h0010) begin n_err++; $display("FAIL single_wr_addr got %h exp 0010", avm_address); end
    n_cmp++; if (avm_writedata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_wdata got %h exp deadbeef", avm_writedata); end
    n_cmp++; if (avs_m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL single_m0_wait got %b exp 0", avs_m0_waitrequest); end
    n_cmp++; if (avs_m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL single_m1_wait0 got %b exp 1", avs_m1_waitrequest); end
    cyc();
    avs_m0_write = 0; avs_m0_read = 1;
    #2;
    n_cmp++; if (avm_write !== 1'b0) begin n_err++; $display("FAIL single_write_1cyc got %b exp 0", avm_write); end
    n_cmp++; if (avm_read !== 1'b1) begin n_err++; $display("FAIL single_avm_read got %b exp 1", avm_read); end
    n_cmp++; if (avs_m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL single_m1_wait1 got %b exp 1", avs_m1_waitrequest); end
    cyc();
    avs_m0_read = 0;
    #2;
    n_cmp++; if (avs_m0_readdatavalid !== 1'b1) begin n_err++; $display("FAIL single_rdv got %b exp 1", avs_m0_readdatavalid); end
    n_cmp++; if (avs_m0_readdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_rdata got %h exp deadbeef", avs_m0_readdata); end
    n_cmp++; if (avs_m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL single_m1_rdv got %b exp 0", avs_m1_readdatavalid); end
    n_cmp++; if (avs_m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL single_m1_wait2 got %b exp 1", avs_m1_waitrequest); end
    cyc();
    #2;
    n_cmp++; if (avs_m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL single_rdv_end got %b exp 0", avs_m0_readdatavalid); end
  endtask

  task automatic test_contention();
    logic [15:0] exp_addr [0:3];
    logic [31:0] exp_data [0:3];
    exp_addr[0] = 16'h0020; exp_addr[1] = 16'h0030; exp_addr[2] = 16'h0020; exp_addr[3] = 16'h0030;
    exp_data[0] = 32'hC0DE0020; exp_data[1] = 32'hC0DE0030; exp_data[2] = 32'hC0DE0020; exp_data[3] = 32'hC0DE0030;
    do_reset();
    avs_m0_read = 1; avs_m0_address = 16'h0020;
    avs_m1_read = 1; avs_m1_address = 16'h0030;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      #2;
      n_cmp++; if (avm_address !== exp_addr[i]) begin n_err++; $display("FAIL cont_addr[%0d] got %h exp %h", i, avm_address, exp_addr[i]); end
      if (i > 0) begin
        n_cmp++; if (avs_m0_readdatavalid !== (i == 1 || i == 3)) begin n_err++; $display("FAIL cont_m0_rdv[%0d] got %b", i, avs_m0_readdatavalid); end
        n_cmp++; if (avs_m1_readdatavalid !== (i == 2)) begin n_err++; $display("FAIL cont_m1_rdv[%0d] got %b", i, avs_m1_readdatavalid); end
        n_cmp++; if (avm_readdata !== exp_data[i-1]) begin n_err++; $display("FAIL cont_data[%0d] got %h exp %h", i, avm_readdata, exp_data[i-1]); end
      end
    end
    cyc();
    clear_masters();
    #2;
    n_cmp++; if (avs_m1_readdatavalid !== 1'b1) begin n_err++; $display("FAIL cont_last_m1_rdv got %b exp 1", avs_m1_readdatavalid); end
    n_cmp++; if (avs_m1_readdata !== 32'hC0DE0030) begin n_err++; $display("FAIL cont_last_data got %h exp c0de0030", avs_m1_readdata); end
  endtask

  task automatic test_lock();
    cyc();
    avs_m1_read = 1; avs_m1_address = 16'h0040; avm_waitrequest = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      if (i == 1) begin avs_m0_read = 1; avs_m0_address = 16'h0050; end
      if (i == 3) avm_waitrequest = 0;
      #2;
      n_cmp++; if (avm_address !== 16'h0040) begin n_err++; $display("FAIL lock_addr[%0d] got %h exp 0040", i, avm_address); end
      n_cmp++; if (avs_m1_waitrequest !== (i != 3)) begin n_err++; $display("FAIL lock_m1_wait[%0d] got %b", i, avs_m1_waitrequest); end
    end
    cyc();
    avs_m1_read = 0;
    #2;
    n_cmp++; if (avm_address !== 16'h0050) begin n_err++; $display("FAIL lock_m0_addr got %h exp 0050", avm_address); end
    n_cmp++; if (avs_m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL lock_m0_wait got %b exp 0", avs_m0_waitrequest); end
    n_cmp++; if (avs_m1_readdatavalid !== 1'b1 || avs_m1_readdata !== 32'hC0DE0040) begin n_err++; $display("FAIL lock_m1_resp got %b/%h exp 1/c0de0040", avs_m1_readdatavalid, avs_m1_readdata); end
    cyc();
    avs_m0_read = 0;
    #2;
    n_cmp++; if (avs_m0_readdatavalid !== 1'b1 || avs_m0_readdata !== 32'hC0DE0050) begin n_err++; $display("FAIL lock_m0_resp got %b/%h exp 1/c0de0050", avs_m0_readdatavalid, avs_m0_readdata); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    mem_auto = 0; avm_readdatavalid = 0; avm_readdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      avs_m0_read = 1; avs_m0_address = 16'h0060 + 16'(i);
      #2;
      n_cmp++; if (avm_read !== 1'b1) begin n_err++; $display("FAIL fifo_read[%0d] got %b exp 1", i, avm_read); end
    end
    cyc();
    avs_m0_address = 16'h0064;
    avs_m1_write = 1; avs_m1_address = 16'h0070; avs_m1_writedata = 32'h12345678;
    #2;
    n_cmp++; if (avm_write !== 1'b1 || avm_address !== 16'h0070) begin n_err++; $display("FAIL fifo_m1_write got %b/%h exp 1/0070", avm_write, avm_address); end
    n_cmp++; if (avs_m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL fifo_m1_wait got %b exp 0", avs_m1_waitrequest); end
    n_cmp++; if (avs_m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL fifo_m0_wait_w got %b exp 1", avs_m0_waitrequest); end
    cyc();
    avs_m1_write = 0; avm_readdatavalid = 1; avm_readdata = 32'hAAAA0060;
    #2;
    n_cmp++; if (avs_m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL fifo_full_wait got %b exp 1", avs_m0_waitrequest); end
    n_cmp++; if (avm_read !== 1'b0) begin n_err++; $display("FAIL fifo_full_avm_read got %b exp 0", avm_read); end
    n_cmp++; if (avs_m0_readdatavalid !== 1'b1 || avs_m0_readdata !== 32'hAAAA0060) begin n_err++; $display("FAIL fifo_pop_resp got %b/%h exp 1/aaaa0060", avs_m0_readdatavalid, avs_m0_readdata); end
    cyc();
    avm_readdatavalid = 0;
    #2;
    n_cmp++; if (avm_read !== 1'b1 || avm_address !== 16'h0064) begin n_err++; $display("FAIL fifo_fifth got %b/%h exp 1/0064", avm_read, avm_address); end
    n_cmp++; if (avs_m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL fifo_fifth_wait got %b exp 0", avs_m0_waitrequest); end
    cyc();
    avs_m0_read = 0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) cyc();
      avm_readdatavalid = 1;
      #2;
      n_cmp++; if (avs_m0_readdatavalid !== 1'b1 || avs_m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL fifo_drain[%0d] got %b%b exp 10", j, avs_m0_readdatavalid, avs_m1_readdatavalid); end
    end
    cyc();
    avm_readdatavalid = 0;
    #2;
    n_cmp++; if (protocol_error !== 1'b0) begin n_err++; $display("FAIL fifo_no_perr got %b exp 0", protocol_error); end
  endtask

  task automatic test_spurious();
    cyc();
    avm_readdatavalid = 1;
    #2;
    n_cmp++; if (avs_m0_readdatavalid !== 1'b0 || avs_m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL spur_rdv got %b%b exp 00", avs_m0_readdatavalid, avs_m1_readdatavalid); end
    cyc();
    avm_readdatavalid = 0;
    #2;
    n_cmp++; if (protocol_error !== 1'b1) begin n_err++; $display("FAIL spur_set got %b exp 1", protocol_error); end
    cyc();
    #2;
    n_cmp++; if (protocol_error !== 1'b1) begin n_err++; $display("FAIL spur_sticky got %b exp 1", protocol_error); end
    cyc();
    reset = 1;
    #2;
    n_cmp++; if (protocol_error !== 1'b0) begin n_err++; $display("FAIL spur_rst got %b exp 0", protocol_error); end
    cyc();
    reset = 0;
    #2;
    n_cmp++; if (protocol_error !== 1'b0) begin n_err++; $display("FAIL spur_after_rst got %b exp 0", protocol_error); end
  endtask

  task automatic test_reset_mid();
    mem_auto = 0; avm_readdatavalid = 0;
    cyc();
    avs_m0_read = 1; avs_m0_address = 16'h0080;
    cyc();
    avs_m0_address = 16'h0081;
    cyc();
    avs_m0_address = 16'h0090; avs_m1_read = 1; avs_m1_address = 16'h00A0;
    #2;
    reset = 1;
    #1;
    n_cmp++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin n_err++; $display("FAIL mid_avm_cmd got %b%b exp 00", avm_read, avm_write); end
    n_cmp++; if (avs_m0_waitrequest !== 1'b1 || avs_m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL mid_wait got %b%b exp 11", avs_m0_waitrequest, avs_m1_waitrequest); end
    avm_readdatavalid = 1;
    #1;
    n_cmp++; if (avs_m0_readdatavalid !== 1'b0 || avs_m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL mid_rdv got %b%b exp 00", avs_m0_readdatavalid, avs_m1_readdatavalid); end
    cyc();
    reset = 0; avm_waitrequest = 1;
    #2;
    n_cmp++; if (avm_address !== 16'h0090 || avm_read !== 1'b1) begin n_err++; $display("FAIL mid_grant got %h/%b exp 0090/1", avm_address, avm_read); end
    n_cmp++; if (avs_m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL mid_m1_wait got %b exp 1", avs_m1_waitrequest); end
    n_cmp++; if (avs_m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL mid_stale_rdv got %b exp 0", avs_m0_readdatavalid); end
    cyc();
    avm_readdatavalid = 0;
    #2;
    n_cmp++; if (protocol_error !== 1'b1) begin n_err++; $display("FAIL mid_perr got %b exp 1", protocol_error); end
    cyc();
    clear_masters(); avm_waitrequest = 0;
    do_reset();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem_model[k] = 32'hC0DE0000 | k;
    reset = 1; mem_auto = 1; rd_acc = 0; rd_addr = 16'h0;
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 32'h0;
    avs_m0_address = 0; avs_m0_byteenable = 4'hF; avs_m0_writedata = 0;
    avs_m1_address = 0; avs_m1_byteenable = 4'hF; avs_m1_writedata = 0;
    clear_masters();
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_fifo_full();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
